// File: rtl/instruction_decode.sv
// instruction_decode: decode stage sitting directly behind instruction fetch.
//
// Holds the IF/ID pipeline register, a REG_COUNT-entry register file with
// write-back bypass, load-use hazard detection (drives the fetch stall) and
// J/JAL/JR/JALR resolution (drives the fetch jump-target bus and PC mux
// select). The decoded instruction is presented to execute through a
// registered ID/EX bundle.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_instruction     fetched instruction
//   i_pc_plus1        word-indexed PC+1 from the fetch adder
//   i_wb_en/addr/data register-file write port from write-back
//   i_ex_mem_read     instruction currently in EX is a load
//   i_ex_rt           destination register of that load
//   o_stall           combinational fetch stall
//   o_jump_sel        combinational fetch PC mux select
//   o_jump_target     combinational fetch jump target (0 when no jump)
//   o_valid .. o_pc_plus1  registered ID/EX bundle
module instruction_decode #(
  parameter int SIZE      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] i_instruction,
  input  logic [SIZE-1:0] i_pc_plus1,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [SIZE-1:0] i_wb_data,
  input  logic            i_ex_mem_read,
  input  logic [4:0]      i_ex_rt,
  output logic            o_stall,
  output logic            o_jump_sel,
  output logic [SIZE-1:0] o_jump_target,
  output logic            o_valid,
  output logic [5:0]      o_opcode,
  output logic [5:0]      o_funct,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_shamt,
  output logic [SIZE-1:0] o_rs_data,
  output logic [SIZE-1:0] o_rt_data,
  output logic [SIZE-1:0] o_imm_ext,
  output logic [SIZE-1:0] o_pc_plus1
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  function automatic logic signed [SIZE-1:0] sign_ext(input logic [15:0] imm);
    return {{(SIZE-16){imm[15]}}, imm};
  endfunction

  // ---------------- IF/ID register (stage p0) ----------------
  logic [SIZE-1:0] instr_p0;
  logic [SIZE-1:0] pc_p0;
  logic            vld_p0;

  logic            stall;
  logic            jump_sel;

  // A taken jump flushes the sequential instruction already fetched;
  // flush and stall never coincide because a jump requires !stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p0 <= '0;
      pc_p0    <= '0;
      vld_p0   <= 1'b0;
    end else if (jump_sel) begin
      instr_p0 <= '0;
      pc_p0    <= '0;
      vld_p0   <= 1'b0;
    end else if (!stall) begin
      instr_p0 <= i_instruction;
      pc_p0    <= i_pc_plus1;
      vld_p0   <= 1'b1;
    end
  end

  // ---------------- register file ----------------
  logic [SIZE-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // ---------------- decode (combinational on p0) ----------------
  logic [5:0]             op, funct;
  logic [4:0]             rs, rt, rd, shamt;
  logic [SIZE-1:0]        rs_data, rt_data;
  logic signed [SIZE-1:0] imm_ext;
  logic                   rt_src, is_j, is_jr;
  logic [SIZE-1:0]        jump_target;

  assign op      = instr_p0[31:26];
  assign rs      = instr_p0[25:21];
  assign rt      = instr_p0[20:16];
  assign rd      = instr_p0[15:11];
  assign shamt   = instr_p0[10:6];
  assign funct   = instr_p0[5:0];
  assign imm_ext = sign_ext(instr_p0[15:0]);

  // Reads of r0 are forced to zero; a same-cycle write-back to a nonzero
  // read address is forwarded so the operand is never stale.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) rs_data = (i_wb_en && (i_wb_addr == rs)) ? i_wb_data : regs[rs];
    if (rt != 5'd0) rt_data = (i_wb_en && (i_wb_addr == rt)) ? i_wb_data : regs[rt];
  end

  assign rt_src = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                  (op == OP_SB) || (op == OP_SH) || (op == OP_SW);

  assign stall = vld_p0 && i_ex_mem_read && (i_ex_rt != 5'd0) &&
                 ((i_ex_rt == rs) || ((i_ex_rt == rt) && rt_src));

  assign is_j     = (op == OP_J) || (op == OP_JAL);
  assign is_jr    = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
  assign jump_sel = vld_p0 && !stall && (is_j || is_jr);

  // PC is word-indexed, so the J-type index is used without a shift.
  always_comb begin
    jump_target = '0;
    if (jump_sel) begin
      if (is_j) jump_target = {pc_p0[31:26], instr_p0[25:0]};
      else      jump_target = rs_data;
    end
  end

  assign o_stall       = stall;
  assign o_jump_sel    = jump_sel;
  assign o_jump_target = jump_target;

  // ---------------- ID/EX register (stage p1) ----------------
  logic                   vld_p1;
  logic [5:0]             op_p1, funct_p1;
  logic [4:0]             rs_p1, rt_p1, rd_p1, shamt_p1;
  logic [SIZE-1:0]        rs_data_p1, rt_data_p1, pc_p1;
  logic signed [SIZE-1:0] imm_p1;

  // A stall sends a zeroed bubble to execute while IF/ID holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall) begin
      if (rst || stall) begin
        vld_p1     <= 1'b0;
        op_p1      <= '0;
        funct_p1   <= '0;
        rs_p1      <= '0;
        rt_p1      <= '0;
        rd_p1      <= '0;
        shamt_p1   <= '0;
        rs_data_p1 <= '0;
        rt_data_p1 <= '0;
        imm_p1     <= '0;
        pc_p1      <= '0;
      end
    end else begin
      vld_p1     <= vld_p0;
      op_p1      <= op;
      funct_p1   <= funct;
      rs_p1      <= rs;
      rt_p1      <= rt;
      rd_p1      <= rd;
      shamt_p1   <= shamt;
      rs_data_p1 <= rs_data;
      rt_data_p1 <= rt_data;
      imm_p1     <= imm_ext;
      pc_p1      <= pc_p0;
    end
  end

  assign o_valid    = vld_p1;
  assign o_opcode   = op_p1;
  assign o_funct    = funct_p1;
  assign o_rs       = rs_p1;
  assign o_rt       = rt_p1;
  assign o_rd       = rd_p1;
  assign o_shamt    = shamt_p1;
  assign o_rs_data  = rs_data_p1;
  assign o_rt_data  = rt_data_p1;
  assign o_imm_ext  = imm_p1;
  assign o_pc_plus1 = pc_p1;

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_instruction, i_pc_plus1, i_wb_data;
  logic        i_wb_en, i_ex_mem_read;
  logic [4:0]  i_wb_addr, i_ex_rt;
  logic        o_stall, o_jump_sel, o_valid;
  logic [31:0] o_jump_target, o_rs_data, o_rt_data, o_imm_ext, o_pc_plus1;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;

  instruction_decode #(.SIZE(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .i_instruction(i_instruction), .i_pc_plus1(i_pc_plus1),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_stall(o_stall), .o_jump_sel(o_jump_sel), .o_jump_target(o_jump_target),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm_ext), .o_pc_plus1(o_pc_plus1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural register array, the instruction waiting
  // in decode, and the bundle execute should see next.
  logic [31:0] mregs [32];
  logic [31:0] m_instr, m_pc;
  logic        m_vld;
  logic        e_valid;
  logic [5:0]  e_op, e_funct;
  logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
  logic [31:0] e_rsd, e_rtd, e_imm, e_pc;
  logic        s_stall, s_jsel;
  logic [31:0] s_tgt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_instr = 0; m_pc = 0; m_vld = 0;
    e_valid = 0; e_op = 0; e_funct = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_shamt = 0;
    e_rsd = 0; e_rtd = 0; e_imm = 0; e_pc = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_wb_en && i_wb_addr == a) return i_wb_data;
    return mregs[a];
  endfunction

  function automatic bit uses_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
  endfunction

  task automatic set_idle();
    i_instruction = 0; i_pc_plus1 = 0; i_wb_en = 0; i_wb_addr = 0; i_wb_data = 0;
    i_ex_mem_read = 0; i_ex_rt = 0;
  endtask

  // One clock: check combinational outputs mid-cycle against the model,
  // advance the model across the edge, then check the ID/EX bundle.
  task automatic step();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, tgt;
    logic        hz, jmp;
    #3;
    op  = m_instr[31:26]; fn = m_instr[5:0];
    rs  = m_instr[25:21]; rt = m_instr[20:16];
    rsd = m_read(rs); rtd = m_read(rt);
    hz  = m_vld && i_ex_mem_read && i_ex_rt != 0 &&
          (i_ex_rt == rs || (i_ex_rt == rt && uses_rt(op)));
    jmp = 0; tgt = 0;
    if (m_vld && !hz) begin
      if (op == 6'h02 || op == 6'h03) begin
        jmp = 1; tgt = {m_pc[31:26], m_instr[25:0]};
      end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
        jmp = 1; tgt = rsd;
      end
    end
    s_stall = o_stall; s_jsel = o_jump_sel; s_tgt = o_jump_target;
    chk("stall", {31'd0, o_stall}, {31'd0, hz});
    chk("jump_sel", {31'd0, o_jump_sel}, {31'd0, jmp});
    chk("jump_target", o_jump_target, tgt);
    @(posedge clk);
    #1;
    if (hz) begin
      e_valid = 0; e_op = 0; e_funct = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_shamt = 0;
      e_rsd = 0; e_rtd = 0; e_imm = 0; e_pc = 0;
    end else begin
      e_valid = m_vld; e_op = op; e_funct = fn; e_rs = rs; e_rt = rt;
      e_rd = m_instr[15:11]; e_shamt = m_instr[10:6]; e_rsd = rsd; e_rtd = rtd;
      e_imm = {{16{m_instr[15]}}, m_instr[15:0]}; e_pc = m_pc;
    end
    if (i_wb_en && i_wb_addr != 0) mregs[i_wb_addr] = i_wb_data;
    if (jmp) begin
      m_instr = 0; m_pc = 0; m_vld = 0;
    end else if (!hz) begin
      m_instr = i_instruction; m_pc = i_pc_plus1; m_vld = 1;
    end
    chk("valid", {31'd0, o_valid}, {31'd0, e_valid});
    chk("opcode", {26'd0, o_opcode}, {26'd0, e_op});
    chk("funct", {26'd0, o_funct}, {26'd0, e_funct});
    chk("rs", {27'd0, o_rs}, {27'd0, e_rs});
    chk("rt", {27'd0, o_rt}, {27'd0, e_rt});
    chk("rd", {27'd0, o_rd}, {27'd0, e_rd});
    chk("shamt", {27'd0, o_shamt}, {27'd0, e_shamt});
    chk("rs_data", o_rs_data, e_rsd);
    chk("rt_data", o_rt_data, e_rtd);
    chk("imm_ext", o_imm_ext, e_imm);
    chk("pc_plus1", o_pc_plus1, e_pc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  ops [7];
    logic [31:0] r;
    ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h28, 6'h29, 6'h08};
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {6'h00, rs, rt, rd, r[10:6], r[5:0]};
      1: return {(r[31] ? 6'h03 : 6'h02), r[25:0]};
      2: return {6'h00, rs, 5'd0, (r[0] ? 5'd31 : 5'd0), 5'd0, (r[1] ? 6'h09 : 6'h08)};
      3: return {ops[$urandom_range(0, 6)], rs, rt, r[15:0]};
      4: return r;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_jsel"}, {31'd0, o_jump_sel}, 32'd0);
    chk({tag, "_tgt"}, o_jump_target, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_fields"}, {o_opcode, o_funct, o_rs, o_rt, o_rd, o_shamt}, 32'd0);
    chk({tag, "_rs_data"}, o_rs_data, 32'd0);
    chk({tag, "_rt_data"}, o_rt_data, 32'd0);
    chk({tag, "_imm"}, o_imm_ext, 32'd0);
    chk({tag, "_pc"}, o_pc_plus1, 32'd0);
  endtask

  initial begin
    rst = 1;
    set_idle();
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    // ADDU R7,R1,R3 with R1=1, R3=2
    set_idle(); i_wb_en = 1; i_wb_addr = 1; i_wb_data = 1; step();
    i_wb_addr = 3; i_wb_data = 2; step();
    set_idle(); i_instruction = 32'h00233821; i_pc_plus1 = 10; step();
    set_idle(); step();
    chk("addu_rs_data", o_rs_data, 32'd1);
    chk("addu_rt_data", o_rt_data, 32'd2);
    chk("addu_rd", {27'd0, o_rd}, 32'd7);
    chk("addu_valid", {31'd0, o_valid}, 32'd1);

    // same-cycle write-back bypass on R5
    set_idle(); i_instruction = 32'h00A03821; step();
    set_idle(); i_wb_en = 1; i_wb_addr = 5; i_wb_data = 32'hDEADBEEF; step();
    chk("bypass_rs_data", o_rs_data, 32'hDEADBEEF);

    // load-use on R1
    set_idle(); i_instruction = 32'h00233821; step();
    set_idle(); i_ex_mem_read = 1; i_ex_rt = 1; step();
    chk("lu_stall", {31'd0, s_stall}, 32'd1);
    chk("lu_bubble_valid", {31'd0, o_valid}, 32'd0);
    set_idle(); step();
    chk("lu_release_stall", {31'd0, s_stall}, 32'd0);
    chk("lu_release_valid", {31'd0, o_valid}, 32'd1);
    chk("lu_release_rd", {27'd0, o_rd}, 32'd7);

    // J to 5 at pc_plus1=3, sequential instruction behind it is flushed
    set_idle(); i_instruction = 32'h08000005; i_pc_plus1 = 3; step();
    set_idle(); i_instruction = 32'h00233821; i_pc_plus1 = 4; step();
    chk("j_sel", {31'd0, s_jsel}, 32'd1);
    chk("j_target", s_tgt, 32'd5);
    chk("j_idex_op", {26'd0, o_opcode}, 32'd2);
    set_idle(); step();
    chk("j_flush_sel", {31'd0, s_jsel}, 32'd0);
    chk("j_flush_valid", {31'd0, o_valid}, 32'd0);

    // JR R1 (R1=7) held by a load-use hazard
    set_idle(); i_wb_en = 1; i_wb_addr = 1; i_wb_data = 7; step();
    set_idle(); i_instruction = 32'h00200008; step();
    set_idle(); i_ex_mem_read = 1; i_ex_rt = 1; step();
    chk("jr_stall", {31'd0, s_stall}, 32'd1);
    chk("jr_held_sel", {31'd0, s_jsel}, 32'd0);
    set_idle(); step();
    chk("jr_sel", {31'd0, s_jsel}, 32'd1);
    chk("jr_target", s_tgt, 32'd7);
    set_idle(); step();

    // randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      i_instruction = rand_instr();
      i_pc_plus1    = $urandom;
      i_wb_en       = 1'($urandom_range(0, 1));
      i_wb_addr     = 5'($urandom_range(0, 7));
      i_wb_data     = $urandom;
      i_ex_mem_read = ($urandom_range(0, 2) == 0);
      i_ex_rt       = 5'($urandom_range(0, 7));
      step();
    end

    // asynchronous reset between edges with a real instruction in flight
    set_idle(); i_instruction = 32'h00233821; i_pc_plus1 = 32'h55; step();
    step();
    #2;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // registers read zero after reset
    set_idle(); i_instruction = 32'h00233821; step();
    set_idle(); step();
    chk("post_rst_rs_data", o_rs_data, 32'd0);
    chk("post_rst_rt_data", o_rt_data, 32'd0);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Holds the IF/ID pipeline register and a 32-entry register file with write-back bypass.
- Detects load-use hazards and drives the fetch stall.
- Resolves J/JAL/JR/JALR, driving the fetch jump-target bus and PC mux select.
- Presents a registered ID/EX bundle to execute.

Parameters:
- SIZE, 32, datapath and instruction width.
- REG_COUNT, 32, number of architectural registers; index width = $clog2(REG_COUNT) = 5.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_instruction  in  SIZE  fetched instruction.
- i_pc_plus1  in  SIZE  fetch adder output; word-indexed PC+1.
- i_wb_en  in  1  register-file write enable from write-back.
- i_wb_addr  in  5  write-back destination register.
- i_wb_data  in  SIZE  write-back data.
- i_ex_mem_read  in  1  instruction currently in EX is a load.
- i_ex_rt  in  5  destination register of that load.
- o_stall  out  1  combinational; to fetch stall input.
- o_jump_sel  out  1  combinational; to fetch PC mux select.
- o_jump_target  out  SIZE  combinational; to fetch jump-target input.
- o_valid  out  1  ID/EX entry holds a real instruction.
- o_opcode  out  6  registered instr[31:26].
- o_funct  out  6  registered instr[5:0].
- o_rs, o_rt, o_rd  out  5 each  registered register fields.
- o_shamt  out  5  registered instr[10:6].
- o_rs_data, o_rt_data  out  SIZE  registered operand values.
- o_imm_ext  out  SIZE  registered sign-extended instr[15:0].
- o_pc_plus1  out  SIZE  registered PC+1 of the instruction.

Behaviour:
- Reset (asynchronous, any time including mid-stall):
  - IF/ID instruction = 0 (NOP), IF/ID pc = 0, IF/ID valid = 0.
  - All registered outputs = 0.
  - All 32 registers = 0.
- IF/ID register priority per posedge: flush (o_jump_sel=1) loads NOP with valid=0; else o_stall holds contents; else captures i_instruction and i_pc_plus1 with valid=1.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Write occurs on posedge when i_wb_en=1.
  - Read bypass: if i_wb_en=1, i_wb_addr≠0 and i_wb_addr equals a read address, that read returns i_wb_data in the same cycle.
- rt-as-source: opcode 0 (R-type), 0x04, 0x05, 0x28, 0x29, 0x2B.
- Load-use hazard: o_stall = IF/ID valid & i_ex_mem_read & i_ex_rt≠0 & (i_ex_rt==rs | (i_ex_rt==rt & rt is a source)).
- Jumps (require IF/ID valid & !o_stall):
  - J (0x02), JAL (0x03): target = {pc[31:26], instr[25:0]}; no shift, because the PC is word-indexed.
  - JR (op 0, funct 0x08), JALR (op 0, funct 0x09): target = rs data after bypass.
  - o_jump_sel=1 whenever one of these is taken. When o_jump_sel=0, o_jump_target = 0.
- Jump latency: fetch takes the target on the same edge, and the already-fetched sequential instruction is discarded by the IF/ID flush, giving a one-cycle bubble.
- Stalled jump: o_jump_sel stays 0 until the hazard clears, then asserts.
- ID/EX register:
  - On o_stall: inserts a bubble; all outputs go to 0 and o_valid=0.
  - Otherwise: captures the decode of IF/ID, with o_valid = IF/ID valid.
  - Latency is one cycle from IF/ID to outputs.
- Simultaneous events: stall and flush are mutually exclusive by construction. Write-back and a read of the same register in the same cycle resolve through the bypass.
- Sign extension: o_imm_ext = {{16{instr[15]}}, instr[15:0]}.

Test Plan:
1. Reset asserted mid-operation, asynchronously between edges -> all outputs 0 immediately, without waiting for a clock edge; registers read 0 afterwards.
2. Write R1=1 and R3=2 via write-back, then decode ADDU R7,R1,R3 (0x00233821) -> next cycle: o_rs_data=1, o_rt_data=2, o_rd=7, o_valid=1.
3. Bypass: write-back R5=0xDEADBEEF in the same cycle that decode reads R5 -> o_rs_data=0xDEADBEEF.
4. Load-use: i_ex_mem_read=1, i_ex_rt=1, ADDU R7,R1,R3 in ID -> o_stall=1 for one cycle, ID/EX o_valid=0; next cycle with i_ex_mem_read=0 -> instruction proceeds.
5. J with instr[25:0]=5 at pc_plus1=3 -> o_jump_sel=1, o_jump_target=5; the following IF/ID content is a NOP with valid=0.
6. JR R1 with R1=7 while a load to R1 is in EX -> o_stall=1 and o_jump_sel=0; after the hazard clears -> o_jump_sel=1, target=7.
